// File: rtl/hazard_unit_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state
// encodings, EX operand forward selects and the register-tag width.
package hazard_unit_pkg;

  localparam int REG_W = 5;

  typedef logic [REG_W-1:0] reg_idx_t;

  typedef enum logic [1:0] {
    HZ_INIT    = 2'b00,
    HZ_RUN     = 2'b01,
    HZ_LUSTALL = 2'b10
  } hz_state_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  // A producer tag matches a consumer tag only for a real register; x0 is
  // hard-wired to zero, so it never creates a dependency.
  function automatic logic tag_hit(input reg_idx_t producer, input reg_idx_t consumer);
    return (producer != '0) && (producer == consumer);
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline <-> hazard controller signal bundle. The pipeline (master) supplies
// register tags and control bits; the hazard unit (slave) returns stall, flush,
// forward selects and its debug state.
interface hazard_unit_if;
  import hazard_unit_pkg::*;

  reg_idx_t    Rs1D, Rs2D;
  reg_idx_t    Rs1E, Rs2E, RdE;
  logic        MemReadE, RegWriteE;
  reg_idx_t    RdM, RdW;
  logic        RegWriteM, RegWriteW;
  logic        PCSrcE;

  logic        StallF, StallD;
  logic        FlushD, FlushE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [1:0]  HazState;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, MemReadE, RegWriteE,
           RdM, RdW, RegWriteM, RegWriteW, PCSrcE,
    input  StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, HazState
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, MemReadE, RegWriteE,
           RdM, RdW, RegWriteM, RegWriteW, PCSrcE,
    output StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, HazState
  );

endinterface

// File: rtl/hazard_unit_forward_sel.sv
// Combinational forward-select for one EX operand: a MEM-stage producer wins
// over a WB-stage producer, and x0 is never forwarded.
module forward_sel
  import hazard_unit_pkg::*;
(
  input  reg_idx_t rs_e,
  input  reg_idx_t rd_m,
  input  logic     reg_write_m,
  input  reg_idx_t rd_w,
  input  logic     reg_write_w,
  output fwd_sel_e fwd
);

  // Priority compare, youngest producer first.
  always_comb begin
    fwd = FWD_RF;
    if (reg_write_m && tag_hit(rd_m, rs_e)) begin
      fwd = FWD_MEM;
    end else if (reg_write_w && tag_hit(rd_w, rs_e)) begin
      fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller for the 5-stage RV32 core.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// HZ_INIT    | post-reset purge; FlushD/FlushE held for INIT_FLUSH_CYCLES
// HZ_RUN     | normal operation; stall/flush/forward from pipeline tags
// HZ_LUSTALL | one-cycle load-use stall in progress; returns to HZ_RUN
//
// Optional feature macro: HAZARD_PERF_EN adds saturating performance
// counters (PerfLoadUse, PerfRedirect, PerfStallCyc) and their ports.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int INIT_FLUSH_CYCLES = 3,
  parameter int PERF_W            = 32
) (
  input  logic              clk,
  input  logic              reset,
  hazard_unit_if.slave      hz
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_W-1:0] PerfLoadUse,
  output logic [PERF_W-1:0] PerfRedirect,
  output logic [PERF_W-1:0] PerfStallCyc
`endif
);

  localparam logic [3:0] INIT_LOAD = 4'(INIT_FLUSH_CYCLES);

  if (INIT_FLUSH_CYCLES < 1 || INIT_FLUSH_CYCLES > 15 || PERF_W < 1) begin : g_bad_param
    $error("hazard_unit: INIT_FLUSH_CYCLES must be 1..15 and PERF_W >= 1");
  end

  hz_state_e  state_q, state_d;
  logic [3:0] init_cnt_q, init_cnt_d;

  logic       lw_stall;
  logic       stall;
  logic       flush_d, flush_e;
  fwd_sel_e   fwd_a, fwd_b;
  logic [1:0] fwd_a_out, fwd_b_out;

  forward_sel u_fwd_a (
    .rs_e        (hz.Rs1E),
    .rd_m        (hz.RdM),
    .reg_write_m (hz.RegWriteM),
    .rd_w        (hz.RdW),
    .reg_write_w (hz.RegWriteW),
    .fwd         (fwd_a)
  );

  forward_sel u_fwd_b (
    .rs_e        (hz.Rs2E),
    .rd_m        (hz.RdM),
    .reg_write_m (hz.RegWriteM),
    .rd_w        (hz.RdW),
    .reg_write_w (hz.RegWriteW),
    .fwd         (fwd_b)
  );

  // Load-use hazard: a load in EX feeds a source of the instruction in ID.
  always_comb begin
    lw_stall = hz.MemReadE & (tag_hit(hz.RdE, hz.Rs1D) | tag_hit(hz.RdE, hz.Rs2D));
  end

  // State register and purge counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= HZ_INIT;
      init_cnt_q <= INIT_LOAD;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // Next state and stall/flush/forward outputs. A taken branch outranks a
  // load-use stall: the ID instruction is wrong-path, so squash, not hold.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    stall      = 1'b0;
    flush_d    = 1'b0;
    flush_e    = 1'b0;
    fwd_a_out  = FWD_RF;
    fwd_b_out  = FWD_RF;
    case (state_q)
      HZ_INIT: begin
        flush_d    = 1'b1;
        flush_e    = 1'b1;
        init_cnt_d = init_cnt_q - 4'd1;
        if (init_cnt_q <= 4'd1) begin
          state_d = HZ_RUN;
        end
      end
      HZ_RUN, HZ_LUSTALL: begin
        stall     = lw_stall & ~hz.PCSrcE;
        flush_d   = hz.PCSrcE;
        flush_e   = hz.PCSrcE | lw_stall;
        fwd_a_out = fwd_a;
        fwd_b_out = fwd_b;
        // The bubble injected into EX clears MemReadE, so a stall lasts one cycle.
        state_d   = (state_q == HZ_RUN && stall) ? HZ_LUSTALL : HZ_RUN;
      end
      default: begin
        state_d = HZ_INIT;
      end
    endcase
  end

  // Drive the controls back onto the pipeline bundle.
  always_comb begin
    hz.StallF    = stall;
    hz.StallD    = stall;
    hz.FlushD    = flush_d;
    hz.FlushE    = flush_e;
    hz.ForwardAE = fwd_a_out;
    hz.ForwardBE = fwd_b_out;
    hz.HazState  = state_q;
  end

  // The EX bubble must have removed the load, so no load-use can remain.
  a_lustall_no_lw : assert property (
    @(posedge clk) disable iff (reset) (state_q == HZ_LUSTALL) |-> !lw_stall
  );

`ifdef HAZARD_PERF_EN
  localparam logic [PERF_W-1:0] PERF_MAX = '1;

  logic [PERF_W-1:0] perf_lu_q, perf_lu_d;
  logic [PERF_W-1:0] perf_rd_q, perf_rd_d;
  logic [PERF_W-1:0] perf_sc_q, perf_sc_d;

  // Saturating increments; counters never wrap.
  always_comb begin
    perf_lu_d = perf_lu_q;
    perf_rd_d = perf_rd_q;
    perf_sc_d = perf_sc_q;
    if (stall && perf_lu_q != PERF_MAX) begin
      perf_lu_d = perf_lu_q + 1'b1;
    end
    if (stall && perf_sc_q != PERF_MAX) begin
      perf_sc_d = perf_sc_q + 1'b1;
    end
    if (hz.PCSrcE && state_q != HZ_INIT && perf_rd_q != PERF_MAX) begin
      perf_rd_d = perf_rd_q + 1'b1;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_lu_q <= '0;
      perf_rd_q <= '0;
      perf_sc_q <= '0;
    end else begin
      perf_lu_q <= perf_lu_d;
      perf_rd_q <= perf_rd_d;
      perf_sc_q <= perf_sc_d;
    end
  end

  assign PerfLoadUse  = perf_lu_q;
  assign PerfRedirect = perf_rd_q;
  assign PerfStallCyc = perf_sc_q;
`endif

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the 5-stage RV32 core. It consumes the register tags and control bits latched by the decode/execute pipeline register and later stages. It produces the stall and flush controls that drive that register (FlushE) and the fetch/decode registers, plus operand forwarding selects for the EX stage. Sequential content comprises a post-reset pipeline-purge sequencer, a hazard-event FSM, and optional saturating performance counters.

## Interface
Parameters:
- INIT_FLUSH_CYCLES, 3: cycles FlushD/FlushE are held after reset release; legal range 1–15.
- PERF_W, 32: width of each performance counter.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- Rs1D, Rs2D  in  5 each  source registers of the instruction in ID
- Rs1E, Rs2E, RdE  in  5 each  source and destination tags of the instruction in EX
- MemReadE  in  1  EX instruction is a load
- RegWriteE  in  1  EX instruction writes rd
- RdM, RdW  in  5 each  destination tags in MEM and WB
- RegWriteM, RegWriteW  in  1 each  write enables in MEM and WB
- PCSrcE  in  1  taken branch or jump resolved in EX this cycle
- StallF, StallD  out  1 each  hold the PC register and the IF/ID register
- FlushD, FlushE  out  1 each  bubble the IF/ID and ID/EX registers
- ForwardAE, ForwardBE  out  2 each  EX operand select: 00 = register file, 10 = MEM result, 01 = WB result
- HazState  out  2  FSM state, for debug
- PerfLoadUse, PerfRedirect, PerfStallCyc  out  PERF_W each  counters (present only with HAZARD_PERF_EN)

## Operation
FSM states: INIT=00, RUN=01, LUSTALL=10.

- **INIT** (entered on reset):
  - A 4-bit counter loads INIT_FLUSH_CYCLES and decrements each cycle.
  - FlushD=FlushE=1, StallF=StallD=0, Forward*=00.
  - Exit to RUN the cycle after the counter reaches 1.
- **Load-use detection:** lwStall = MemReadE & (RdE≠0) & (RdE==Rs1D | RdE==Rs2D).
- **RUN:**
  - StallF = StallD = lwStall & ~PCSrcE.
  - FlushD = PCSrcE.
  - FlushE = PCSrcE | lwStall.
  - If lwStall & ~PCSrcE, go to LUSTALL.
- **LUSTALL:**
  - Outputs are computed as in RUN.
  - Always return to RUN next cycle. The bubble injected into EX clears MemReadE, so a load-use stall lasts exactly 1 cycle.
  - lwStall=1 while in LUSTALL is a protocol error. Assertion only; outputs still follow the equations.
- **Priority:** PCSrcE dominates lwStall. The ID instruction is wrong-path, so it is squashed rather than stalled.
- **Forwarding (per operand, A shown; B uses Rs2E):**
  - 10 if RegWriteM & RdM≠0 & RdM==Rs1E.
  - Otherwise 01 if RegWriteW & RdW≠0 & RdW==Rs1E.
  - Otherwise 00.
  - MEM beats WB. x0 is never forwarded.
- **Reset mid-operation:** asynchronous return to INIT. The counter reloads and all counters clear.

## Timing
- Stall, flush and forward outputs are combinational from inputs and state, valid in the same cycle. Latency 0.
- State, init counter and perf counters update on posedge clk.
- Reset values:
  - StallF = StallD = 0.
  - FlushD = FlushE = 1.
  - ForwardAE = ForwardBE = 00.
  - HazState = 00.
  - Perf* = 0.
- FlushD/FlushE are high for exactly INIT_FLUSH_CYCLES rising edges after reset release.
- Counters:
  - PerfLoadUse and PerfStallCyc increment on every cycle with StallD=1.
  - PerfRedirect increments on every cycle with PCSrcE=1 in RUN or LUSTALL.
  - All counters saturate at all-ones and never wrap.

## Configuration
- HAZARD_PERF_EN defined: the three counters and their ports exist and behave as above.
- HAZARD_PERF_EN undefined: ports and logic are absent, and stall/flush/forward behaviour is identical.

## Structure
- Shared core package holds:
  - State encodings HZ_INIT / HZ_RUN / HZ_LUSTALL.
  - Forward-select constants FWD_RF=00, FWD_WB=01, FWD_MEM=10.
  - Register-index width 5.
- One sub-module, forward_sel, is instantiated twice (operands A and B). Each instance is combinational and contains the priority compare.

## Test plan
- **Reset release:** reset high 2 cycles then low → FlushD=FlushE=1 for 3 edges, then HazState=01 with both flushes 0.
- **Load-use:** RdE=5, MemReadE=1, Rs1D=5 → StallF=StallD=FlushE=1 for one cycle; HazState 01→10→01; PerfLoadUse=1.
- **Load to x0:** RdE=0, MemReadE=1, Rs1D=0 → no stall, FlushE=0.
- **Taken branch with load-use:** PCSrcE=1 together with lwStall → StallD=0, FlushD=FlushE=1, PerfRedirect +1, PerfLoadUse unchanged.
- **Forwarding priority:** RdM=RdW=7, both RegWrite=1, Rs1E=7 → ForwardAE=10. Drop RegWriteM → 01. Set RdW=0 → 00.
- **Saturation:** with PERF_W=4, hold a stall source for 20 cycles → PerfStallCyc=15, then stays 15.
